// File: rtl/conv_checker.sv
// -----------------------------------------------------------------------------
// conv_checker
//   Convergence check for the FastICA fixed-point loop. After every
//   symmetric-orthogonalization pass it consumes N_COMP signed dot products
//   d_i = w_new_i . w_old_i and tracks the worst | |d_i| - 1.0 |. It then does
//   one of three things:
//     - declares convergence,
//     - declares a timeout after MAX_ITER unconverged passes, or
//     - pulses iter_start to launch the next iteration.
//
// Ports
//   clk_conv    in   block clock
//   go_conv     in   async active-low reset (low clears, high runs)
//   symm_busy   in   busy flag of the orthogonalization stage
//   dot_valid   in   dot_data valid this cycle
//   dot_data    in   signed d_i, component order 0..N_COMP-1
//   dot_ready   out  sample accepted when dot_valid & dot_ready
//   iter_start  out  one-cycle pulse: run next fixed-point iteration
//   conv_busy   out  high in every state except DONE
//   converged   out  sticky, last pass met tolerance
//   timeout     out  sticky, MAX_ITER passes without convergence
//   iter_cnt    out  number of completed, unconverged passes
//   max_dev     out  maximum deviation of the last completed pass
// -----------------------------------------------------------------------------
module conv_checker #(
    parameter int N_COMP   = 4,
    parameter int DW       = 16,
    parameter int FRAC     = 14,
    parameter int TOL      = 16,
    parameter int MAX_ITER = 100,
    parameter int ITER_W   = 8
) (
    input  logic                 clk_conv,
    input  logic                 go_conv,
    input  logic                 symm_busy,
    input  logic                 dot_valid,
    input  logic signed [DW-1:0] dot_data,
    output logic                 dot_ready,
    output logic                 iter_start,
    output logic                 conv_busy,
    output logic                 converged,
    output logic                 timeout,
    output logic [ITER_W-1:0]    iter_cnt,
    output logic [DW-1:0]        max_dev
);

    localparam int CNT_W = $clog2(N_COMP + 1);

    localparam logic [DW-1:0]     ONE    = {{(DW-1){1'b0}}, 1'b1} << FRAC;
    localparam logic [DW-1:0]     MAXPOS = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]     MINNEG = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0]     TOL_V  = DW'(TOL);
    localparam logic [ITER_W-1:0] MAX_V  = ITER_W'(MAX_ITER);
    localparam logic [CNT_W-1:0]  LAST_V = CNT_W'(N_COMP);

    typedef enum logic [2:0] {
        S_WAIT_BUSY,
        S_WAIT_IDLE,
        S_COLLECT,
        S_DECIDE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [DW-1:0]     r_run_max;
    logic [DW-1:0]     r_max_dev;
    logic [ITER_W-1:0] r_iter;
    logic              r_converged;
    logic              r_timeout;

    logic [DW-1:0]     w_raw;
    logic [DW-1:0]     w_abs;
    logic [DW-1:0]     w_dev;
    logic              w_accept;
    logic              w_pass_ok;
    logic [ITER_W-1:0] w_iter_inc;

    // |d| with the most negative code saturated, then distance from 1.0.
    always_comb begin
        w_raw = dot_data;
        if (w_raw == MINNEG)
            w_abs = MAXPOS;
        else if (w_raw[DW-1])
            w_abs = -w_raw;
        else
            w_abs = w_raw;
        w_dev = (w_abs <= ONE) ? (ONE - w_abs) : (w_abs - ONE);
    end

    // dot_ready drops as soon as the N_COMP-th sample is in, so extra valid
    // cycles are never counted. The pass then spends one more COLLECT cycle
    // before DECIDE, which puts the flags two edges after the last accept.
    assign dot_ready  = (r_state == S_COLLECT) && (r_cnt != LAST_V);
    assign iter_start = (r_state == S_NEXT);
    assign conv_busy  = (r_state != S_DONE);
    assign converged  = r_converged;
    assign timeout    = r_timeout;
    assign iter_cnt   = r_iter;
    assign max_dev    = r_max_dev;

    assign w_accept   = dot_valid && dot_ready;
    assign w_pass_ok  = (r_run_max <= TOL_V);
    assign w_iter_inc = r_iter + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_WAIT_BUSY: if (symm_busy)          w_state_nxt = S_WAIT_IDLE;
            S_WAIT_IDLE: if (!symm_busy)         w_state_nxt = S_COLLECT;
            S_COLLECT:   if (r_cnt == LAST_V)    w_state_nxt = S_DECIDE;
            S_DECIDE: begin
                if (w_pass_ok || (w_iter_inc == MAX_V))
                    w_state_nxt = S_DONE;
                else
                    w_state_nxt = S_NEXT;
            end
            S_NEXT:      w_state_nxt = S_WAIT_BUSY;
            S_DONE:      w_state_nxt = S_DONE;
            default:     w_state_nxt = S_WAIT_BUSY;
        endcase
    end

    always_ff @(posedge clk_conv or negedge go_conv) begin
        if (!go_conv) begin
            r_state <= S_WAIT_BUSY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_conv or negedge go_conv) begin
        if (!go_conv) begin
            r_cnt       <= '0;
            r_run_max   <= '0;
            r_max_dev   <= '0;
            r_iter      <= '0;
            r_converged <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            // Fresh pass starts when the orthogonalization stage goes idle.
            if ((r_state == S_WAIT_IDLE) && !symm_busy) begin
                r_cnt     <= '0;
                r_run_max <= '0;
            end
            if (w_accept) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_dev > r_run_max)
                    r_run_max <= w_dev;
            end
            if (r_state == S_DECIDE) begin
                r_max_dev <= r_run_max;
                // Tolerance is tested first so convergence on the final
                // allowed pass is reported as converged, not timeout.
                if (w_pass_ok) begin
                    r_converged <= 1'b1;
                end else begin
                    r_iter <= w_iter_inc;
                    if (w_iter_inc == MAX_V)
                        r_timeout <= 1'b1;
                end
            end
        end
    end

endmodule
